wb_trace_monitor: RTL and testbench

//  Multi-channel writeback-trace capture for LA32R cores, superscalar-ready.

---
 rtl/la32r_trace_pkg.sv | 13 +
 rtl/trace_mwfifo.sv | 61 ++++++
 rtl/wb_trace_monitor.sv | 117 +++++++++++
 tb/tb_wb_trace_monitor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la32r_trace_pkg.sv
// Shared writeback-trace event type for the LA32R trace monitor and its FIFO.
package la32r_trace_pkg;

  localparam int unsigned TRACE_EVT_W = 71;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic [1:0]  ch;
  } trace_evt_t;

endpackage

// File: rtl/trace_mwfifo.sv
// Multi-write, single-read FIFO of trace events. Writers present compacted slots
// 0..wr_num-1; the caller guarantees wr_num never exceeds DEPTH - level.
module trace_mwfifo
  import la32r_trace_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(NUM_CH+1)-1:0]  wr_num,
  input  trace_evt_t [NUM_CH-1:0]      wr_evt,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output trace_evt_t                   rd_evt,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(NUM_CH + 1);

  trace_evt_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_next;
  logic             valid_q;
  logic             do_rd;

  assign do_rd      = valid_q & rd_ready;
  assign level_next = level_q + LVL_W'(wr_num) - LVL_W'(do_rd);

  // Occupancy is tracked explicitly; pointer equality is never used for full/empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(wr_num);
      rd_ptr  <= rd_ptr + PTR_W'(do_rd);
      level_q <= level_next;
      valid_q <= (level_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (CNT_W'(i) < wr_num) begin
        mem[wr_ptr + PTR_W'(i)] <= wr_evt[i];
      end
    end
  end

  assign rd_valid = valid_q;
  assign rd_evt   = valid_q ? mem[rd_ptr] : '0;
  assign level    = level_q;

endmodule

// File: rtl/wb_trace_monitor.sv
// Writeback-trace capture: filters commit ports, compacts surviving writes into a
// FIFO drained on a valid/ready stream, and keeps commit/drop/timeout status.
module wb_trace_monitor
  import la32r_trace_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned SKIP_R0 = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*32-1:0]     in_pc,
  input  logic [NUM_CH*4-1:0]      in_wen,
  input  logic [NUM_CH*5-1:0]      in_wnum,
  input  logic [NUM_CH*32-1:0]     in_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [4:0]               out_wnum,
  output logic [31:0]              out_wdata,
  output logic [1:0]               out_ch,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              commit_cnt,
  output logic [15:0]              drop_cnt,
  output logic                     overflow,
  output logic                     timeout
);

  localparam int unsigned CNT_W  = $clog2(NUM_CH + 1);
  localparam int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT);

  trace_evt_t [NUM_CH-1:0] slot;
  trace_evt_t              head;
  logic [CNT_W-1:0]        n_elig;
  logic [CNT_W-1:0]        n_commit;
  logic [CNT_W-1:0]        n_keep;
  logic [CNT_W-1:0]        n_drop;
  logic [LVL_W-1:0]        fifo_level;
  logic [LVL_W-1:0]        free_slots;
  logic [16:0]             drop_sum;
  logic [IDLE_W-1:0]       idle_cnt;
  logic                    any_valid;

  // Filter and compact eligible channels into ascending slots.
  always_comb begin
    slot     = '0;
    n_elig   = '0;
    n_commit = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      n_commit = n_commit + CNT_W'(in_valid[c]);
      if (in_valid[c] && (in_wen[4*c +: 4] != 4'h0) &&
          !((SKIP_R0 != 0) && (in_wnum[5*c +: 5] == 5'd0))) begin
        slot[SEL_W'(n_elig)] = '{pc:    in_pc[32*c +: 32],
                                 wnum:  in_wnum[5*c +: 5],
                                 wdata: in_wdata[32*c +: 32],
                                 ch:    2'(c)};
        n_elig = n_elig + CNT_W'(1);
      end
    end
  end

  // Free space is the start-of-cycle view; a same-cycle pop does not help.
  assign free_slots = LVL_W'(DEPTH) - fifo_level;
  assign n_keep     = (LVL_W'(n_elig) > free_slots) ? CNT_W'(free_slots) : n_elig;
  assign n_drop     = n_elig - n_keep;
  assign drop_sum   = {1'b0, drop_cnt} + 17'(n_drop);
  assign any_valid  = |in_valid;

  trace_mwfifo #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_num   (n_keep),
    .wr_evt   (slot),
    .rd_ready (out_ready),
    .rd_valid (out_valid),
    .rd_evt   (head),
    .level    (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      commit_cnt <= commit_cnt + 32'(n_commit);
      if (n_drop != '0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      if (any_valid) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_W'(TIMEOUT - 1)) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
      if (!any_valid && (idle_cnt == IDLE_W'(TIMEOUT - 1))) begin
        timeout <= 1'b1;
      end
    end
  end

  assign out_pc    = head.pc;
  assign out_wnum  = head.wnum;
  assign out_wdata = head.wdata;
  assign out_ch    = head.ch;
  assign level     = fifo_level;

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Bench for wb_trace_monitor: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_wb_trace_monitor;
  import la32r_trace_pkg::*;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_CH-1:0]      in_valid;
  logic [NUM_CH*32-1:0]   in_pc;
  logic [NUM_CH*4-1:0]    in_wen;
  logic [NUM_CH*5-1:0]    in_wnum;
  logic [NUM_CH*32-1:0]   in_wdata;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_pc;
  logic [4:0]             out_wnum;
  logic [31:0]            out_wdata;
  logic [1:0]             out_ch;
  logic [$clog2(DEPTH):0] level;
  logic [31:0]            commit_cnt;
  logic [15:0]            drop_cnt;
  logic                   overflow;
  logic                   timeout;

  always #5 clk = ~clk;

  wb_trace_monitor #(
    .NUM_CH  (NUM_CH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .SKIP_R0 (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_wen     (in_wen),
    .in_wnum    (in_wnum),
    .in_wdata   (in_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_wnum   (out_wnum),
    .out_wdata  (out_wdata),
    .out_ch     (out_ch),
    .level      (level),
    .commit_cnt (commit_cnt),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow),
    .timeout    (timeout)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  trace_evt_t  mq[$];
  logic [31:0] m_commit;
  int          m_drop;
  bit          m_ovf;
  bit          m_to;
  int          m_idle;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    in_valid = '0;
    in_pc    = '0;
    in_wen   = '0;
    in_wnum  = '0;
    in_wdata = '0;
  endtask

  task automatic set_ch(input int c, input logic [31:0] pc, input logic [3:0] wen,
                        input logic [4:0] wnum, input logic [31:0] wdata);
    in_valid[c]         = 1'b1;
    in_pc[32*c +: 32]   = pc;
    in_wen[4*c +: 4]    = wen;
    in_wnum[5*c +: 5]   = wnum;
    in_wdata[32*c +: 32] = wdata;
  endtask

  // Compare every visible output against the model's current state.
  task automatic check_state();
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("level", 64'(level), 64'(mq.size()));
    chk("commit_cnt", 64'(commit_cnt), 64'(m_commit));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("timeout", 64'(timeout), 64'(m_to));
    if (mq.size() != 0) begin
      chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
      chk("out_wnum", 64'(out_wnum), 64'(mq[0].wnum));
      chk("out_wdata", 64'(out_wdata), 64'(mq[0].wdata));
      chk("out_ch", 64'(out_ch), 64'(mq[0].ch));
    end
  endtask

  // Advance the reference model by one clock using the currently driven inputs.
  task automatic model_step();
    int         free;
    int         kept;
    trace_evt_t e;
    free = int'(DEPTH) - mq.size();
    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    kept = 0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (!in_valid[c]) continue;
      m_commit = m_commit + 32'd1;
      if (in_wen[4*c +: 4] == 4'h0 || in_wnum[5*c +: 5] == 5'd0) continue;
      if (kept < free) begin
        e.pc    = in_pc[32*c +: 32];
        e.wnum  = in_wnum[5*c +: 5];
        e.wdata = in_wdata[32*c +: 32];
        e.ch    = 2'(c);
        mq.push_back(e);
        kept++;
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end
    if (in_valid != '0) m_idle = 0;
    else m_idle++;
    if (m_idle >= int'(TIMEOUT)) m_to = 1'b1;
  endtask

  task automatic cycle();
    check_state();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    m_commit = '0;
    m_drop   = 0;
    m_ovf    = 1'b0;
    m_to     = 1'b0;
    m_idle   = 0;
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int ready_bias;
    int act;
    reset     = 1'b1;
    out_ready = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;

    // Single event on channel 0
    do_reset();
    out_ready = 1'b1;
    set_ch(0, 32'h1c000000, 4'hF, 5'd5, 32'h12345678);
    cycle();
    clear_inputs();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_pc", 64'(out_pc), 64'h1c000000);
    chk("t1_wnum", 64'(out_wnum), 64'd5);
    chk("t1_wdata", 64'(out_wdata), 64'h12345678);
    chk("t1_ch", 64'(out_ch), 64'd0);
    chk("t1_commit", 64'(commit_cnt), 64'd1);
    cycle();
    chk("t1_level", 64'(level), 64'd0);

    // Two events in one cycle emerge in channel order
    do_reset();
    out_ready = 1'b1;
    set_ch(0, 32'h1c000004, 4'hF, 5'd1, 32'hAAAA0001);
    set_ch(1, 32'h1c000008, 4'h3, 5'd2, 32'hBBBB0002);
    cycle();
    clear_inputs();
    chk("t2_pc0", 64'(out_pc), 64'h1c000004);
    chk("t2_commit", 64'(commit_cnt), 64'd2);
    cycle();
    chk("t2_pc1", 64'(out_pc), 64'h1c000008);
    chk("t2_ch1", 64'(out_ch), 64'd1);
    cycle();
    chk("t2_empty", 64'(out_valid), 64'd0);

    // Filtered events: r0 destination and zero write enable
    do_reset();
    out_ready = 1'b1;
    set_ch(0, 32'h1c00000c, 4'hF, 5'd0, 32'h1);
    set_ch(1, 32'h1c000010, 4'h0, 5'd3, 32'h2);
    cycle();
    clear_inputs();
    chk("t3_valid", 64'(out_valid), 64'd0);
    chk("t3_commit", 64'(commit_cnt), 64'd2);
    cycle();
    chk("t3_valid2", 64'(out_valid), 64'd0);

    // Overflow with a stalled consumer, then an in-order drain
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_ch(0, 32'h1c000100 + 32'(8*i), 4'hF, 5'd7, 32'(i));
      set_ch(1, 32'h1c000104 + 32'(8*i), 4'hF, 5'd8, 32'(i + 100));
      cycle();
    end
    clear_inputs();
    chk("t4_level", 64'(level), 64'd16);
    chk("t4_drop", 64'(drop_cnt), 64'd2);
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_head", 64'(out_pc), 64'h1c000100);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) cycle();
    chk("t4_drained", 64'(level), 64'd0);

    // Idle timeout and its stickiness
    do_reset();
    for (int i = 0; i < 7; i++) cycle();
    chk("t5_before", 64'(timeout), 64'd0);
    cycle();
    chk("t5_set", 64'(timeout), 64'd1);
    set_ch(1, 32'h1c000200, 4'hF, 5'd9, 32'h9);
    cycle();
    clear_inputs();
    chk("t5_sticky", 64'(timeout), 64'd1);

    // Reset mid-operation discards buffered events
    do_reset();
    out_ready = 1'b0;
    set_ch(0, 32'h1c000300, 4'hF, 5'd1, 32'h1);
    set_ch(1, 32'h1c000304, 4'hF, 5'd2, 32'h2);
    cycle();
    cycle();
    clear_inputs();
    set_ch(0, 32'h1c000310, 4'hF, 5'd3, 32'h3);
    cycle();
    clear_inputs();
    chk("t6_level5", 64'(level), 64'd5);
    do_reset();
    chk("t6_level", 64'(level), 64'd0);
    chk("t6_commit", 64'(commit_cnt), 64'd0);
    chk("t6_drop", 64'(drop_cnt), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    chk("t6_to", 64'(timeout), 64'd0);

    // Randomized traffic with shifting consumer and producer rates
    ready_bias = 50;
    act        = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        ready_bias = int'($urandom_range(0, 100));
        act        = int'($urandom_range(0, 100));
      end
      out_ready = ($urandom_range(0, 99) < ready_bias);
      clear_inputs();
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if ($urandom_range(0, 99) < act) begin
          set_ch(c, $urandom, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
        end
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle();
    end
    clear_inputs();
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
